// File: rtl/pwm_peripheral_if.sv
// Control-register and output bundle between the SPI register block and the PWM peripheral.
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral: sclk-domain control registers are synchronised and filtered into clk,
// duty is double-buffered at period boundaries, outputs are registered.

// One control register: 3-flop synchroniser plus a two-sample stability filter.
module pwm_sync_filter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
            // Only accept a value seen identically on two consecutive cycles.
            if (s2 == s3) q <= s2;
        end
    end
endmodule

module pwm_peripheral #(
    parameter int PRESCALE = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_peripheral_if.slave  bus
);
    localparam int NUM_REGS  = 5;
    localparam int NUM_LANES = 16;
    localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [NUM_REGS-1:0][7:0] raw, comm;
    logic [NUM_LANES-1:0]     en_out, en_pwm, out_nxt;
    logic [7:0]               duty_c, duty_active, pwm_cnt;
    logic [PW-1:0]            presc;
    logic                     tick, wrap, level;

    assign raw = {bus.pwm_duty_cycle, bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0,
                  bus.en_reg_out_15_8, bus.en_reg_out_7_0};

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_sync
        pwm_sync_filter #(.W(8)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (raw[g]),
            .q     (comm[g])
        );
    end

    assign en_out = {comm[1], comm[0]};
    assign en_pwm = {comm[3], comm[2]};
    assign duty_c = comm[4];

    assign tick  = (presc == PRE_LAST);
    assign wrap  = tick && (pwm_cnt == 8'hFF);
    assign level = (duty_active == 8'hFF) ? 1'b1 : (pwm_cnt < duty_active);

    always_comb begin
        out_nxt = '0;
        for (int i = 0; i < NUM_LANES; i++)
            out_nxt[i] = en_out[i] & (en_pwm[i] ? level : 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc            <= '0;
            pwm_cnt          <= '0;
            duty_active      <= '0;
            bus.period_start <= 1'b0;
            bus.out          <= '0;
        end else begin
            presc            <= tick ? '0 : presc + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 8'd1;
            // Duty committed on this same edge is not yet visible here; it lands next wrap.
            if (wrap) duty_active <= duty_c;
            bus.period_start <= wrap;
            bus.out          <= out_nxt;
        end
    end
endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomised bench for pwm_peripheral: PRESCALE=1 and PRESCALE=13 instances share stimulus and are
// checked every cycle against a period/commit-rule model, plus directed timing checks.
module tb_pwm_peripheral;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] rin [5];
    always #5 clk = ~clk;

    pwm_peripheral_if bus0 ();
    pwm_peripheral_if bus1 ();

    assign bus0.en_reg_out_7_0  = rin[0];
    assign bus0.en_reg_out_15_8 = rin[1];
    assign bus0.en_reg_pwm_7_0  = rin[2];
    assign bus0.en_reg_pwm_15_8 = rin[3];
    assign bus0.pwm_duty_cycle  = rin[4];
    assign bus1.en_reg_out_7_0  = rin[0];
    assign bus1.en_reg_out_15_8 = rin[1];
    assign bus1.en_reg_pwm_7_0  = rin[2];
    assign bus1.en_reg_pwm_15_8 = rin[3];
    assign bus1.pwm_duty_cycle  = rin[4];

    pwm_peripheral #(.PRESCALE(1))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    pwm_peripheral #(.PRESCALE(13)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state. k = clk edges since reset release.
    int          ps_div [2] = '{1, 13};
    int          k;
    logic [7:0]  hist [5][4];    // input seen at edges k, k-1, k-2, k-3
    logic [7:0]  comm [5], comm_prev [5];
    logic [7:0]  da [2];
    logic [15:0] oexp [2];
    logic        psexp [2];
    // Observation helpers
    logic [15:0] obs_out [2];
    logic        obs_ps [2];
    int          hi_acc [2], last_hi [2], last_ps_k [2], gap [2];

    task automatic model_reset();
        k = 0;
        for (int r = 0; r < 5; r++) begin
            comm[r] = '0; comm_prev[r] = '0;
            for (int j = 0; j < 4; j++) hist[r][j] = '0;
        end
        for (int d = 0; d < 2; d++) begin
            da[d] = '0; oexp[d] = '0; psexp[d] = 1'b0;
            hi_acc[d] = 0; last_hi[d] = -1; last_ps_k[d] = 0; gap[d] = -1;
        end
    endtask

    task automatic model_edge();
        int cnt_prev;
        logic lvl;
        logic [15:0] en, sel;
        k++;
        for (int r = 0; r < 5; r++) begin
            for (int j = 3; j > 0; j--) hist[r][j] = hist[r][j-1];
            hist[r][0] = rin[r];
        end
        comm_prev = comm;
        for (int r = 0; r < 5; r++)
            if (hist[r][2] == hist[r][3]) comm[r] = hist[r][2];
        en  = {comm_prev[1], comm_prev[0]};
        sel = {comm_prev[3], comm_prev[2]};
        for (int d = 0; d < 2; d++) begin
            cnt_prev = ((k - 1) / ps_div[d]) % 256;
            lvl = (da[d] == 8'hFF) ? 1'b1 : (cnt_prev < int'(da[d]));
            for (int i = 0; i < 16; i++) oexp[d][i] = en[i] ? (sel[i] ? lvl : 1'b1) : 1'b0;
            psexp[d] = (k % (256 * ps_div[d])) == 0;
            if (psexp[d]) da[d] = comm_prev[4];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        obs_out[0] = bus0.out; obs_ps[0] = bus0.period_start;
        obs_out[1] = bus1.out; obs_ps[1] = bus1.period_start;
        for (int d = 0; d < 2; d++) begin
            chk(d == 0 ? "out_p1" : "out_p13", obs_out[d], oexp[d]);
            chk(d == 0 ? "ps_p1" : "ps_p13", obs_ps[d], psexp[d]);
            hi_acc[d] += obs_out[d][0];
            if (obs_ps[d]) begin
                last_hi[d] = hi_acc[d]; hi_acc[d] = 0;
                gap[d] = k - last_ps_k[d]; last_ps_k[d] = k;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_ps(input int d, input int bound);
        int n = 0;
        do begin tick(); n++; end while (!obs_ps[d] && n < bound);
        if (!obs_ps[d]) chk("ps_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] dt);
        rin[0] = eo[7:0]; rin[1] = eo[15:8];
        rin[2] = ep[7:0]; rin[3] = ep[15:8];
        rin[4] = dt;
    endtask

    initial begin
        logic saw;
        set_regs(16'h0, 16'h0, 8'h0);
        model_reset();
        run(3);
        @(negedge clk) rst_n = 1'b1;

        // 1: static outputs, 5-clk enable latency, period_start spacing
        set_regs(16'h00FF, 16'h0000, 8'h00);
        run(4);
        chk("en_lat4", bus0.out, 32'h0);
        run(1);
        chk("en_lat5", bus0.out, 32'h00FF);
        wait_ps(0, 300);
        wait_ps(0, 300);
        chk("ps_gap_p1", gap[0], 256);

        // 2: 50% PWM on all lanes
        set_regs(16'hFFFF, 16'hFFFF, 8'h80);
        repeat (3) wait_ps(0, 300);
        chk("hi_80", last_hi[0], 128);

        // 3: duty extremes
        rin[4] = 8'h00;
        repeat (3) wait_ps(0, 300);
        chk("hi_00", last_hi[0], 0);
        rin[4] = 8'hFF;
        repeat (3) wait_ps(0, 300);
        chk("hi_FF", last_hi[0], 256);

        // 4: mid-period duty change is deferred to the following period
        rin[4] = 8'h40;
        repeat (3) wait_ps(0, 300);
        chk("hi_40", last_hi[0], 64);
        run(100);
        rin[4] = 8'hC0;
        wait_ps(0, 300);
        chk("hi_40_keep", last_hi[0], 64);
        wait_ps(0, 300);
        chk("hi_C0", last_hi[0], 192);

        // 5: glitch filtering on the enable register
        set_regs(16'h0000, 16'h0000, 8'h80);
        run(10);
        rin[0] = 8'hFF; run(1); rin[0] = 8'h00;
        run(10);
        chk("glitch1", bus0.out, 32'h0);
        rin[0] = 8'hFF; run(3); rin[0] = 8'h00;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus0.out[7:0] == 8'hFF) saw = 1'b1;
        end
        chk("pulse3", saw, 1'b1);

        // 6: mid-period reset, then restart on both prescalers
        set_regs(16'hFFFF, 16'hFFFF, 8'h80);
        run(100);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out_p1", bus0.out, 32'h0);
        chk("rst_out_p13", bus1.out, 32'h0);
        run(3);
        @(negedge clk) rst_n = 1'b1;
        wait_ps(0, 300);
        chk("rst_first_hi_p1", last_hi[0], 0);
        wait_ps(1, 3400);
        chk("rst_first_hi_p13", last_hi[1], 0);
        wait_ps(1, 3400);
        chk("ps_gap_p13", gap[1], 3328);
        chk("hi_80_p13", last_hi[1], 13 * 128);

        // Random register traffic, including short glitches
        for (int it = 0; it < 60; it++) begin
            rin[$urandom_range(0, 4)] = 8'($urandom);
            run($urandom_range(1, 40));
        end
        run(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
